// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the mccomp multicycle control sequencer:
// instruction encodings, state codes, ALU codes and datapath select codes.
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Sequencer states
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXE   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXE   = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Coarse ALU request from the sequencer to the ALU decoder
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_OR    = 2'b11;

    // Register destination select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Write-back data select
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MDR = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

    // ALU B input select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // True for every opcode the sequencer knows how to execute
    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J)    || (op == OP_JAL)  ||
               (op == OP_BEQ)   || (op == OP_BNE)  || (op == OP_ADDI) ||
               (op == OP_ORI)   || (op == OP_LW)   || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: turns the sequencer's coarse ALU request plus the
// R-type funct field into a concrete ALU operation code.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_illegal
);

    // Map the request; funct is only consulted for R-type execution
    always_comb begin
        alu_ctrl      = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_op)
            AOP_ADD: alu_ctrl = ALU_ADD;
            AOP_SUB: alu_ctrl = ALU_SUB;
            AOP_OR:  alu_ctrl = ALU_OR;
            default: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the mccomp MIPS datapath. Walks each
// instruction through fetch/decode/execute/memory/writeback and drives all
// datapath enables and mux selects as Moore outputs of the state register.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic       instr_done
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] alu_op;
    logic       illegal_decode;
    logic       funct_illegal;

    mc_alu_dec u_alu_dec (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_ctrl      (alu_ctrl),
        .funct_illegal (funct_illegal)
    );

    // State register with synchronous reset back to the fetch state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; opcode/funct come from the IR, stable after fetch
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_next = S_MEMADR;
                    OP_RTYPE:        state_next = S_REXE;
                    OP_BEQ, OP_BNE:  state_next = S_BRANCH;
                    OP_ADDI, OP_ORI: state_next = S_IEXE;
                    OP_J:            state_next = S_JUMP;
                    OP_JAL:          state_next = S_JAL;
                    default:         state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = S_MEMWB;
            S_REXE:   state_next = funct_illegal ? S_FETCH : S_RWB;
            S_IEXE:   state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore output decode; reset masks every enable and parks selects at fetch values
    always_comb begin
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        branch_ne      = 1'b0;
        iord           = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        reg_dst        = RD_RT;
        mem_to_reg     = MTR_ALU;
        alu_src_a      = 1'b0;
        alu_src_b      = SRCB_B;
        ext_op         = 1'b0;
        alu_op         = AOP_ADD;
        pc_source      = PCS_ALU;
        illegal_decode = 1'b0;
        instr_done     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write  = 1'b1;
                alu_src_b = SRCB_4;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b      = SRCB_BRANCH;
                illegal_decode = !op_legal(opcode);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = MTR_MDR;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_REXE: begin
                alu_src_a = 1'b1;
                alu_op    = AOP_FUNCT;
            end
            S_RWB: begin
                reg_dst    = RD_RD;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = AOP_SUB;
                pc_source     = PCS_ALUOUT;
                pc_write_cond = 1'b1;
                branch_ne     = (opcode == OP_BNE);
                instr_done    = 1'b1;
            end
            S_IEXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_ORI) begin
                    alu_op = AOP_OR;
                end else begin
                    ext_op = 1'b1;
                end
            end
            S_IWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_source  = PCS_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_source  = PCS_JUMP;
                pc_write   = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = MTR_PC;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write       = 1'b0;
            pc_write_cond  = 1'b0;
            branch_ne      = 1'b0;
            iord           = 1'b0;
            mem_write      = 1'b0;
            ir_write       = 1'b0;
            reg_write      = 1'b0;
            reg_dst        = RD_RT;
            mem_to_reg     = MTR_ALU;
            alu_src_a      = 1'b0;
            alu_src_b      = SRCB_4;
            ext_op         = 1'b0;
            alu_op         = AOP_ADD;
            pc_source      = PCS_ALU;
            illegal_decode = 1'b0;
            instr_done     = 1'b0;
        end
    end

    // funct_illegal can only fire in R-type execute, where alu_op selects funct
    assign illegal = illegal_decode | funct_illegal;
    assign pc_en   = pc_write | (pc_write_cond & (zero ^ branch_ne));

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm. A per-instruction model lists the
// expected control word for every cycle (with a care mask), and each
// scenario task drives opcode/funct/zero and compares cycle by cycle.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en, iord, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic       alu_src_a, ext_op, illegal, instr_done;
    logic [3:0] alu_ctrl;

    mc_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_ctrl   (alu_ctrl),
        .pc_source  (pc_source),
        .illegal    (illegal),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit positions inside the packed control word
    localparam int B_DONE = 0;
    localparam int B_ILL  = 1;
    localparam int B_PCS  = 2;
    localparam int B_ALU  = 4;
    localparam int B_EXT  = 8;
    localparam int B_ASB  = 9;
    localparam int B_ASA  = 11;
    localparam int B_MTR  = 12;
    localparam int B_RD   = 14;
    localparam int B_RW   = 16;
    localparam int B_IRW  = 17;
    localparam int B_MW   = 18;
    localparam int B_IORD = 19;
    localparam int B_PCEN = 20;

    // Enables are always checked; selects only where they matter
    localparam logic [20:0] EN_CARE  = 21'h170003;
    localparam logic [20:0] ALL_CARE = 21'h1FFFFF;
    // During reset: enables 0, alu_src_b=01, alu_ctrl=ADD, everything else 0
    localparam logic [20:0] RST_VEC  = 21'h000220;

    logic [20:0] obs;
    assign obs = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, ext_op, alu_ctrl, pc_source, illegal, instr_done};

    int n_cmp;
    int n_fail;
    logic [20:0] cur_v;
    logic [20:0] cur_c;
    logic [20:0] exp_q[$];
    logic [20:0] care_q[$];

    task automatic fld(input int lsb, input int w, input int val);
        logic [20:0] m;
        m = ((21'd1 << w) - 21'd1) << lsb;
        cur_c = cur_c | m;
        cur_v = (cur_v & ~m) | ((21'(val) << lsb) & m);
    endtask

    task automatic push_cycle();
        exp_q.push_back(cur_v);
        care_q.push_back(cur_c);
        cur_v = '0;
        cur_c = EN_CARE;
    endtask

    // Reference: what the datapath must be told each cycle for one instruction
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic legal;
        int   code;
        exp_q.delete();
        care_q.delete();
        cur_v = '0;
        cur_c = EN_CARE;
        // fetch: IR <= mem[PC], PC <= PC + 4
        fld(B_IRW, 1, 1); fld(B_PCEN, 1, 1); fld(B_IORD, 1, 0); fld(B_ASA, 1, 0);
        fld(B_ASB, 2, 1); fld(B_ALU, 4, 2); fld(B_PCS, 2, 0);
        push_cycle();
        // decode: ALUOut <= PC + (sext(imm) << 2)
        legal = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
        fld(B_ASA, 1, 0); fld(B_ASB, 2, 3); fld(B_ALU, 4, 2);
        if (!legal) fld(B_ILL, 1, 1);
        push_cycle();
        if (!legal) return;
        case (op)
            6'h23, 6'h2B: begin
                fld(B_ASA, 1, 1); fld(B_ASB, 2, 2); fld(B_EXT, 1, 1); fld(B_ALU, 4, 2);
                push_cycle();
                if (op == 6'h23) begin
                    fld(B_IORD, 1, 1);
                    push_cycle();
                    fld(B_RD, 2, 0); fld(B_MTR, 2, 1); fld(B_RW, 1, 1); fld(B_DONE, 1, 1);
                    push_cycle();
                end else begin
                    fld(B_IORD, 1, 1); fld(B_MW, 1, 1); fld(B_DONE, 1, 1);
                    push_cycle();
                end
            end
            6'h00: begin
                fld(B_ASA, 1, 1); fld(B_ASB, 2, 0);
                case (fn)
                    6'h20:   code = 2;
                    6'h22:   code = 6;
                    6'h24:   code = 0;
                    6'h25:   code = 1;
                    6'h2A:   code = 7;
                    default: code = -1;
                endcase
                if (code >= 0) begin
                    fld(B_ALU, 4, code);
                    push_cycle();
                    fld(B_RD, 2, 1); fld(B_MTR, 2, 0); fld(B_RW, 1, 1); fld(B_DONE, 1, 1);
                    push_cycle();
                end else begin
                    fld(B_ILL, 1, 1);
                    push_cycle();
                end
            end
            6'h04, 6'h05: begin
                // beq taken when equal (zero=1); bne taken when not equal
                fld(B_ASA, 1, 1); fld(B_ASB, 2, 0); fld(B_ALU, 4, 6); fld(B_PCS, 2, 1);
                fld(B_DONE, 1, 1);
                fld(B_PCEN, 1, (op == 6'h04) ? int'(z) : int'(!z));
                push_cycle();
            end
            6'h08, 6'h0D: begin
                fld(B_ASA, 1, 1); fld(B_ASB, 2, 2);
                if (op == 6'h08) begin
                    fld(B_EXT, 1, 1); fld(B_ALU, 4, 2);
                end else begin
                    fld(B_EXT, 1, 0); fld(B_ALU, 4, 1);
                end
                push_cycle();
                fld(B_RD, 2, 0); fld(B_MTR, 2, 0); fld(B_RW, 1, 1); fld(B_DONE, 1, 1);
                push_cycle();
            end
            6'h02: begin
                fld(B_PCS, 2, 2); fld(B_PCEN, 1, 1); fld(B_DONE, 1, 1);
                push_cycle();
            end
            default: begin
                fld(B_PCS, 2, 2); fld(B_PCEN, 1, 1); fld(B_RD, 2, 2); fld(B_MTR, 2, 2);
                fld(B_RW, 1, 1); fld(B_DONE, 1, 1);
                push_cycle();
            end
        endcase
    endtask

    // Run one instruction from fetch; abort_at>=0 asserts rst in that cycle.
    // Entered and left 1 time unit after a rising edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int abort_at, input string tag);
        int n;
        int bad;
        logic [20:0] e;
        logic [20:0] c;
        model(op, fn, z);
        n = exp_q.size();
        bad = 0;
        for (int i = 0; i < n; i++) begin
            opcode = op;
            funct  = fn;
            zero   = (i == n - 1) ? z : 1'($urandom);
            if (i == abort_at) rst = 1'b1;
            #4;
            if (i == abort_at) begin
                e = RST_VEC;
                c = ALL_CARE;
            end else begin
                e = exp_q[i];
                c = care_q[i];
            end
            n_cmp++;
            if ((obs & c) !== (e & c)) begin
                n_fail++;
                bad++;
                $display("FAIL %s cycle %0d: got ctrl=%06h need %06h (care %06h)",
                         tag, i, obs, e, c);
            end
            @(posedge clk);
            #1;
            rst = 1'b0;
            if (i == abort_at) break;
        end
        $display("instr %-8s op=%02h fn=%02h zero=%0d cycles=%0d abort=%0d errors=%0d",
                 tag, op, fn, z, n, abort_at, bad);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            zero   = 1'b1;
            #4;
            n_cmp++;
            if (obs !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got ctrl=%06h need %06h", i, obs, RST_VEC);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        $display("reset held 2 cycles, released");
    endtask

    task automatic test_lw();
        run_instr(6'h23, 6'h00, 1'b0, -1, "lw");
        run_instr(6'h23, 6'h2A, 1'b1, -1, "lw");
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h22, 1'b0, -1, "sub");
        run_instr(6'h00, 6'h3F, 1'b0, -1, "r_bad");
        run_instr(6'h00, 6'h20, 1'b1, -1, "add");
        run_instr(6'h00, 6'h24, 1'b0, -1, "and");
        run_instr(6'h00, 6'h25, 1'b1, -1, "or");
        run_instr(6'h00, 6'h2A, 1'b0, -1, "slt");
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b1, -1, "beq_t");
        run_instr(6'h04, 6'h00, 1'b0, -1, "beq_nt");
        run_instr(6'h05, 6'h00, 1'b0, -1, "bne_t");
        run_instr(6'h05, 6'h00, 1'b1, -1, "bne_nt");
    endtask

    task automatic test_jumps_imm();
        run_instr(6'h03, 6'h00, 1'b0, -1, "jal");
        run_instr(6'h02, 6'h11, 1'b1, -1, "j");
        run_instr(6'h08, 6'h00, 1'b0, -1, "addi");
        run_instr(6'h0D, 6'h00, 1'b1, -1, "ori");
        run_instr(6'h2B, 6'h00, 1'b0, -1, "sw");
        run_instr(6'h3F, 6'h00, 1'b0, -1, "op_bad");
    endtask

    task automatic test_reset_mid();
        // sw cycle 3 is the memory write; reset there must suppress it
        run_instr(6'h2B, 6'h00, 1'b0, 3, "sw_rst");
        run_instr(6'h08, 6'h00, 1'b0, -1, "addi");
        run_instr(6'h23, 6'h00, 1'b0, 2, "lw_rst");
        run_instr(6'h03, 6'h00, 1'b0, -1, "jal");
    endtask

    task automatic test_random();
        logic [5:0] ops[10];
        logic [5:0] fns[6];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h03, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            fn = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
            run_instr(op, fn, 1'($urandom), -1, "rand");
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        opcode = '0;
        funct  = '0;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_jumps_imm();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
